// File: rtl/ts_pkt_rx.sv
// Transport-stream byte receiver: aligns on sync bytes, packs four bytes per
// 32-bit word and presents them on a valid/ready output with error counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | not aligned; waiting for a sync-flagged SYNC_BYTE
// RECV  | aligned; packing bytes of the current packet
// DROP  | aligned but output overflowed; discarding until next sync
module ts_pkt_rx #(
  parameter int         PACK_BYTE_SIZE = 188,
  parameter logic [7:0] SYNC_BYTE      = 8'h47
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ts_valid,
  input  logic        ts_sync,
  input  logic [7:0]  ts_data,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        locked,
  output logic [31:0] pkt_count,
  output logic [15:0] err_sync_count,
  output logic [15:0] err_ovf_count
);

  localparam int CW = $clog2(PACK_BYTE_SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(PACK_BYTE_SIZE - 1);
  localparam logic [CW-1:0] WORD0_CNT = CW'(3);

  typedef enum logic [1:0] {HUNT, RECV, DROP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] byte_cnt;
  logic [23:0]   pack;

  logic sync_ok;
  logic cnt_zero;
  logic start_pkt;
  logic sync_err;
  logic data_byte;
  logic word_done;
  logic load_word;
  logic ovf;

  assign sync_ok   = ts_valid && ts_sync && (ts_data == SYNC_BYTE);
  assign cnt_zero  = (byte_cnt == '0);
  assign word_done = data_byte && (byte_cnt[1:0] == 2'b11);
  assign load_word = word_done && (!m_tvalid || m_tready);
  assign ovf       = word_done && m_tvalid && !m_tready;
  assign locked    = (state != HUNT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT: if (sync_ok) state_next = RECV;
      RECV: begin
        if (sync_err && !sync_ok) state_next = HUNT;
        else if (ovf)             state_next = DROP;
      end
      DROP: if (sync_ok) state_next = RECV;
      default: state_next = HUNT;
    endcase
  end

  // A good sync byte always opens a packet, whichever state it arrives in.
  always_comb begin
    start_pkt = sync_ok;
    sync_err  = 1'b0;
    data_byte = 1'b0;
    case (state)
      HUNT: sync_err = ts_valid && ts_sync && !sync_ok;
      RECV: begin
        if (cnt_zero) sync_err = ts_valid && !sync_ok;
        else          sync_err = ts_valid && ts_sync;
        data_byte = ts_valid && !ts_sync && !cnt_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt       <= '0;
      pack           <= '0;
      m_tdata        <= '0;
      m_tvalid       <= 1'b0;
      m_tuser        <= 1'b0;
      m_tlast        <= 1'b0;
      pkt_count      <= '0;
      err_sync_count <= '0;
      err_ovf_count  <= '0;
    end else begin
      if (start_pkt) begin
        byte_cnt <= CW'(1);
        pack     <= {pack[15:0], ts_data};
      end else if (data_byte) begin
        byte_cnt <= (byte_cnt == LAST_CNT) ? '0 : byte_cnt + 1'b1;
        pack     <= {pack[15:0], ts_data};
      end

      if (load_word) begin
        m_tdata  <= {pack, ts_data};
        m_tvalid <= 1'b1;
        m_tuser  <= (byte_cnt == WORD0_CNT);
        m_tlast  <= (byte_cnt == LAST_CNT);
        if (byte_cnt == LAST_CNT) pkt_count <= pkt_count + 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (sync_err && err_sync_count != 16'hFFFF)
        err_sync_count <= err_sync_count + 1'b1;
      if (ovf && !sync_err && err_ovf_count != 16'hFFFF)
        err_ovf_count <= err_ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ts_pkt_rx.sv
// Bench for ts_pkt_rx: drives byte streams, predicts output words into a
// scoreboard queue and compares them as the DUT hands them off.
module tb_ts_pkt_rx;

  localparam int P = 188;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ts_valid;
  logic        ts_sync;
  logic [7:0]  ts_data;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic        locked;
  logic [31:0] pkt_count;
  logic [15:0] err_sync_count;
  logic [15:0] err_ovf_count;

  int total = 0;
  int bad = 0;
  int n_words = 0;
  int n_user = 0;
  int n_last = 0;
  bit stall_done = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_word;

  ts_pkt_rx #(.PACK_BYTE_SIZE(P), .SYNC_BYTE(8'h47)) dut (
    .clk(clk), .rst_n(rst_n),
    .ts_valid(ts_valid), .ts_sync(ts_sync), .ts_data(ts_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast), .locked(locked),
    .pkt_count(pkt_count), .err_sync_count(err_sync_count),
    .err_ovf_count(err_ovf_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: each accepted word is checked against the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      n_words++;
      if (m_tuser) n_user++;
      if (m_tlast) n_last++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got=%h user=%b last=%b exp=none", m_tdata, m_tuser, m_tlast);
      end else begin
        exp_word = exp_q.pop_front();
        if ({m_tuser, m_tlast, m_tdata} !== exp_word) begin
          bad++;
          $display("FAIL sb_word got=%b_%b_%h exp=%b_%b_%h", m_tuser, m_tlast, m_tdata,
                   exp_word[33], exp_word[32], exp_word[31:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] pbyte(int seed, int i);
    return (i == 0) ? 8'h47 : 8'(seed * 7 + i);
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
    end
  endtask

  task automatic send_byte(logic s, logic [7:0] d);
    @(posedge clk); #1;
    ts_valid = 1'b1;
    ts_sync  = s;
    ts_data  = d;
  endtask

  task automatic send_pkt(int seed, int first, int last, bit push, bit gap);
    logic [33:0] e;
    for (int i = first; i <= last; i++) begin
      if (gap && i > first) idle($urandom_range(0, 2));
      send_byte(i == 0, pbyte(seed, i));
      if (push && (i % 4) == 3) begin
        e = {(i == 3), (i == P - 1), pbyte(seed, i - 3), pbyte(seed, i - 2),
             pbyte(seed, i - 1), pbyte(seed, i)};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    idle(6);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0 words pending", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; ts_valid = 1'b0; ts_sync = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ts_valid = 1'b0; ts_sync = 1'b0; ts_data = 8'h00; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tuser, m_tlast, locked} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=0000", {m_tvalid, m_tuser, m_tlast, locked});
    end
    total++;
    if (m_tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", m_tdata); end
    total++;
    if ({pkt_count, err_sync_count, err_ovf_count} !== 64'h0) begin
      bad++; $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", pkt_count, err_sync_count, err_ovf_count);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_first_word();
    do_reset();
    exp_q.push_back({1'b1, 1'b0, 32'h47010203});
    send_byte(1'b1, 8'h47);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03);
    idle(1);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tuser} !== 2'b11) begin bad++; $display("FAIL first_flags got=%b exp=11", {m_tvalid, m_tuser}); end
    total++;
    if (m_tdata !== 32'h47010203) begin bad++; $display("FAIL first_tdata got=%h exp=47010203", m_tdata); end
    send_pkt(0, 4, P - 1, 1, 0);
    drain();
    total++;
    if (pkt_count !== 32'd1) begin bad++; $display("FAIL first_pktcnt got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_back_to_back();
    int w0, u0, l0;
    do_reset();
    w0 = n_words; u0 = n_user; l0 = n_last;
    send_pkt(1, 0, 0, 1, 0);
    idle(1);
    @(negedge clk);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL b2b_locked_early got=%b exp=1", locked); end
    send_pkt(1, 1, P - 1, 1, 0);
    for (int p = 2; p <= 7; p++) send_pkt(p, 0, P - 1, 1, 0);
    drain();
    total++;
    if (n_words - w0 != 329) begin bad++; $display("FAIL b2b_words got=%0d exp=329", n_words - w0); end
    total++;
    if (n_user - u0 != 7 || n_last - l0 != 7) begin
      bad++; $display("FAIL b2b_user_last got=%0d/%0d exp=7/7", n_user - u0, n_last - l0);
    end
    total++;
    if (pkt_count !== 32'd7) begin bad++; $display("FAIL b2b_pktcnt got=%0d exp=7", pkt_count); end
    total++;
    if (err_sync_count !== 16'd0 || err_ovf_count !== 16'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL b2b_status got=%0d/%0d/%b exp=0/0/1", err_sync_count, err_ovf_count, locked);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_pkt(9, 0, P - 1, 1, 1);
    send_pkt(10, 0, P - 1, 1, 1);
    drain();
    total++;
    if (pkt_count !== 32'd2 || err_sync_count !== 16'd0) begin
      bad++; $display("FAIL gaps_counts got=%0d/%0d exp=2/0", pkt_count, err_sync_count);
    end
  endtask

  task automatic test_ready_stall();
    do_reset();
    stall_done = 0;
    fork
      begin
        send_pkt(5, 0, P - 1, 1, 1);
        send_pkt(6, 0, P - 1, 1, 1);
        idle(1);
        stall_done = 1;
      end
      begin
        int k = 0;
        while (!stall_done) begin
          @(posedge clk); #1;
          m_tready = ((k % 4) == 0);
          k++;
        end
        m_tready = 1'b1;
      end
    join
    drain();
    total++;
    if (pkt_count !== 32'd2 || err_ovf_count !== 16'd0) begin
      bad++; $display("FAIL stall_counts got=%0d/%0d exp=2/0", pkt_count, err_ovf_count);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w0;
    do_reset();
    m_tready = 1'b0;
    w0 = {pbyte(3, 0), pbyte(3, 1), pbyte(3, 2), pbyte(3, 3)};
    send_pkt(3, 0, 3, 1, 0);
    send_pkt(3, 4, 7, 0, 0);
    idle(2);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tuser, m_tlast} !== 3'b110 || m_tdata !== w0) begin
      bad++; $display("FAIL ovf_hold got=%b_%h exp=110_%h", {m_tvalid, m_tuser, m_tlast}, m_tdata, w0);
    end
    total++;
    if (err_ovf_count !== 16'd1 || locked !== 1'b1) begin
      bad++; $display("FAIL ovf_count got=%0d/%b exp=1/1", err_ovf_count, locked);
    end
    send_pkt(3, 8, P - 1, 0, 0);
    idle(1);
    @(negedge clk);
    total++;
    if (err_ovf_count !== 16'd1 || m_tdata !== w0 || pkt_count !== 32'd0) begin
      bad++; $display("FAIL ovf_drop got=%0d/%h/%0d exp=1/%h/0", err_ovf_count, m_tdata, pkt_count, w0);
    end
    @(posedge clk); #1 m_tready = 1'b1;
    idle(2);
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_release got=%b exp=0", m_tvalid); end
    send_pkt(4, 0, P - 1, 1, 0);
    drain();
    total++;
    if (pkt_count !== 32'd1 || err_ovf_count !== 16'd1 || err_sync_count !== 16'd0) begin
      bad++; $display("FAIL ovf_recover got=%0d/%0d/%0d exp=1/1/0", pkt_count, err_ovf_count, err_sync_count);
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    repeat (3) send_byte(1'b0, 8'h47);
    send_byte(1'b1, 8'h46);
    idle(2);
    @(negedge clk);
    total++;
    if (err_sync_count !== 16'd1 || locked !== 1'b0) begin
      bad++; $display("FAIL hunt_bad_sync got=%0d/%b exp=1/0", err_sync_count, locked);
    end
    send_pkt(7, 0, 0, 1, 0);
    idle(1);
    @(negedge clk);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL hunt_lock got=%b exp=1", locked); end
    send_pkt(7, 1, P - 1, 1, 0);
    drain();
    total++;
    if (pkt_count !== 32'd1 || err_sync_count !== 16'd1) begin
      bad++; $display("FAIL hunt_pkt got=%0d/%0d exp=1/1", pkt_count, err_sync_count);
    end
  endtask

  task automatic test_premature();
    int u0, l0;
    do_reset();
    u0 = n_user; l0 = n_last;
    send_pkt(8, 0, 99, 1, 0);
    send_pkt(11, 0, P - 1, 1, 0);
    drain();
    total++;
    if (err_sync_count !== 16'd1 || pkt_count !== 32'd1 || locked !== 1'b1) begin
      bad++; $display("FAIL premature_counts got=%0d/%0d/%b exp=1/1/1", err_sync_count, pkt_count, locked);
    end
    total++;
    if (n_last - l0 != 1 || n_user - u0 != 2) begin
      bad++; $display("FAIL premature_marks got=%0d/%0d exp=1/2", n_last - l0, n_user - u0);
    end
  endtask

  task automatic test_boundary_err();
    send_byte(1'b0, 8'h47);
    idle(1);
    @(negedge clk);
    total++;
    if (err_sync_count !== 16'd2 || locked !== 1'b0) begin
      bad++; $display("FAIL boundary_nosync got=%0d/%b exp=2/0", err_sync_count, locked);
    end
    send_pkt(12, 0, 10, 1, 0);
    send_byte(1'b1, 8'h12);
    idle(1);
    @(negedge clk);
    total++;
    if (err_sync_count !== 16'd3 || locked !== 1'b0) begin
      bad++; $display("FAIL premature_bad got=%0d/%b exp=3/0", err_sync_count, locked);
    end
    drain();
    total++;
    if (pkt_count !== 32'd1) begin bad++; $display("FAIL boundary_pktcnt got=%0d exp=1", pkt_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_pkt(13, 0, 49, 1, 0);
    idle(4);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tuser, m_tlast, locked} !== 4'b0 || m_tdata !== 32'h0) begin
      bad++; $display("FAIL midrst_outs got=%b_%h exp=0000_0", {m_tvalid, m_tuser, m_tlast, locked}, m_tdata);
    end
    total++;
    if ({pkt_count, err_sync_count, err_ovf_count} !== 64'h0) begin
      bad++; $display("FAIL midrst_counts got=%0d/%0d/%0d exp=0/0/0", pkt_count, err_sync_count, err_ovf_count);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send_pkt(13, 50, 60, 0, 0);
    idle(2);
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL midrst_needsync got=%b exp=0", locked); end
    send_pkt(14, 0, P - 1, 1, 0);
    drain();
    total++;
    if (pkt_count !== 32'd1) begin bad++; $display("FAIL midrst_pktcnt got=%0d exp=1", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_gaps();
    test_ready_stall();
    test_overflow();
    test_sync_err();
    test_premature();
    test_boundary_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
